// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       id_control,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             flush,
  output logic [9:0]       ex_control,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_count
);

  logic       ex_is_load;
  logic       rd_match;
  logic       cnt_max;
  logic [9:0] load_control;

  // jal/jalr/auipc also assert memread; the branch bit tells them apart from loads
  assign ex_is_load = ex_valid & ex_control[3] & ~ex_control[1];
  assign rd_match   = (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign stall      = id_valid & ex_is_load & rd_match;
  assign cnt_max    = &bubble_count;

  // memtoreg is only trusted for real loads so stray decoder values never reach WB
  always_comb begin
    load_control = '0;
    if (id_valid) begin
      load_control[9:1] = id_control[9:1];
      load_control[0]   = id_control[0] & id_control[3] & ~id_control[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_control   <= '0;
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      ex_control <= '0;
      ex_valid   <= 1'b0;
    end else if (stall) begin
      ex_control <= '0;
      ex_valid   <= 1'b0;
      if (!cnt_max) bubble_count <= bubble_count + 1'b1;
    end else begin
      ex_control  <= load_control;
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/reset scenarios plus random
// traffic, all checked against a behavioural pipeline model.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [9:0]      id_control;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [2:0]      id_funct3;
  logic            flush;

  logic [9:0]      ex_control, s_control;
  logic            ex_valid, s_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [XLEN-1:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd, s_rs1, s_rs2, s_rd;
  logic [2:0]      ex_funct3, s_funct3;
  logic            stall, s_stall;
  logic [15:0]     bubble_count;
  logic [1:0]      s_bubble_count;

  int total = 0;
  int bad   = 0;

  // model state: what EX should hold and how many bubbles have been inserted
  logic [9:0]      m_ctrl;
  logic            m_valid;
  logic [XLEN-1:0] m_pc, m_d1, m_d2, m_imm;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [2:0]      m_f3;
  int              m_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_control(id_control), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .flush(flush),
    .ex_control(ex_control), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .stall(stall), .bubble_count(bubble_count)
  );

  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_control(id_control), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .flush(flush),
    .ex_control(s_control), .ex_valid(s_valid), .ex_pc(s_pc),
    .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_funct3),
    .stall(s_stall), .bubble_count(s_bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_valid = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_cnt = 0;
  endtask

  // a real load in EX writing a non-zero register that the ID instruction reads
  function automatic logic model_hazard();
    logic ex_load;
    ex_load = m_valid && m_ctrl[3] && !m_ctrl[1];
    return id_valid && ex_load && (m_rd != 0) && (m_rd == id_rs1 || m_rd == id_rs2);
  endfunction

  task automatic check_all();
    int sat;
    sat = (m_cnt > 3) ? 3 : m_cnt;
    chk("ex_control", ex_control, m_ctrl);
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rs1_data", ex_rs1_data, m_d1);
    chk("ex_rs2_data", ex_rs2_data, m_d2);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_rs1", ex_rs1, m_rs1);
    chk("ex_rs2", ex_rs2, m_rs2);
    chk("ex_rd", ex_rd, m_rd);
    chk("ex_funct3", ex_funct3, m_f3);
    chk("bubble_count", bubble_count, m_cnt);
    chk("sat_bubble_count", s_bubble_count, sat);
    chk("sat_ex_control", s_control, m_ctrl);
  endtask

  // called at posedge+1 with new ID inputs already driven
  task automatic step();
    logic hz;
    #1;
    hz = model_hazard();
    chk("stall", stall, hz);
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0; m_ctrl = '0;
    end else if (hz) begin
      m_valid = 1'b0; m_ctrl = '0; m_cnt++;
    end else begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? {id_control[9:1],
                            id_control[0] & id_control[3] & ~id_control[1]} : 10'h0;
      m_pc = id_pc; m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f3 = id_funct3;
    end
    #1;
    check_all();
  endtask

  task automatic set_id(input logic v, input logic [9:0] c, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
    id_valid = v; id_control = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm = $urandom; id_funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("reset_stall", stall, 1'b0);
    #2 reset = 1'b0;
  endtask

  initial begin
    int cnt_before;
    reset = 1'b1; flush = 1'b0;
    set_id(1'b1, 10'h219, 5'd0, 5'd0, 5'd0);
    model_reset();
    #2;
    check_all();
    chk("reset_stall", stall, 1'b0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // load-use: load to x3 then consumer of x3
    set_id(1'b1, 10'h219, 5'd1, 5'd2, 5'd3); step();
    set_id(1'b1, 10'h200, 5'd3, 5'd4, 5'd6);
    #1 chk("lu_stall", stall, 1'b1);
    step();
    chk("lu_valid", ex_valid, 1'b0);
    chk("lu_ctrl", ex_control, 10'h0);
    chk("lu_count", bubble_count, 16'd1);
    chk("lu_stall_after", stall, 1'b0);
    step();

    // pass-through ADD
    set_id(1'b1, 10'h200, 5'd7, 5'd8, 5'd5); id_pc = 32'h40; step();
    chk("pt_ctrl", ex_control, 10'h200);
    chk("pt_rd", ex_rd, 5'd5);
    chk("pt_pc", ex_pc, 32'h40);
    chk("pt_valid", ex_valid, 1'b1);
    chk("pt_stall", stall, 1'b0);

    // x0 exclusion
    set_id(1'b1, 10'h219, 5'd9, 5'd9, 5'd0); step();
    set_id(1'b1, 10'h200, 5'd9, 5'd0, 5'd4);
    #1 chk("x0_stall", stall, 1'b0);
    step();
    // jal in ID: memtoreg must be dropped; then jal in EX must not stall
    set_id(1'b1, 10'h20B, 5'd0, 5'd0, 5'd1); step();
    chk("jal_memtoreg", ex_control, 10'h20A);
    set_id(1'b1, 10'h200, 5'd1, 5'd2, 5'd4);
    #1 chk("jal_stall", stall, 1'b0);
    step();

    // flush beats stall and does not count
    set_id(1'b1, 10'h219, 5'd1, 5'd2, 5'd3); step();
    set_id(1'b1, 10'h200, 5'd3, 5'd4, 5'd6); flush = 1'b1;
    cnt_before = m_cnt;
    #1 chk("fl_stall", stall, 1'b1);
    step();
    flush = 1'b0;
    chk("fl_valid", ex_valid, 1'b0);
    chk("fl_ctrl", ex_control, 10'h0);
    chk("fl_count", bubble_count, 16'(cnt_before));

    // reset, then self-dependent load repeated: 7 bubbles, saturate narrow counter
    do_reset();
    set_id(1'b1, 10'h219, 5'd3, 5'd0, 5'd3);
    for (int i = 0; i < 15; i++) step();
    chk("pre_rst_count", bubble_count, 16'd7);
    chk("pre_rst_valid", ex_valid, 1'b1);
    chk("sat_hold", s_bubble_count, 2'd3);
    do_reset();
    set_id(1'b1, 10'h200, 5'd0, 5'd0, 5'd2); step();
    chk("post_rst_valid", ex_valid, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [9:0] c;
      c = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1)) c[3] = 1'b1;
      if ($urandom_range(0, 3) != 0) c[1] = 1'b0;
      set_id($urandom_range(0, 99) < 85, c, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 9) == 0);
      step();
      if (i == 300) do_reset();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of PC, register data and immediate.
REQ-002 SHALL have parameter CNT_W, default 16: width of bubble_count.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port id_control, input, 10: decoder bundle {regwrite[9], alu_control[8:5], alusrc[4], memread[3], memwrite[2], branch[1], memtoreg[0]}.
REQ-006 SHALL have port id_valid, input, 1: the ID slot holds a real instruction.
REQ-007 SHALL have ports id_pc, id_rs1_data, id_rs2_data and id_imm, input, XLEN each: ID operands.
REQ-008 SHALL have ports id_rs1, id_rs2 and id_rd, input, 5 each: register addresses.
REQ-009 SHALL have port id_funct3, input, 3: funct3 for EX branch and memory sizing.
REQ-010 SHALL have port flush, input, 1: branch or jump resolved taken in EX; kill the ID instruction.
REQ-011 SHALL have outputs ex_control (10), ex_valid (1), ex_pc, ex_rs1_data, ex_rs2_data and ex_imm (XLEN each), ex_rs1, ex_rs2 and ex_rd (5 each), and ex_funct3 (3): registered copies of the ID inputs.
REQ-012 SHALL have port stall, output, 1: combinational; hold PC and the IF/ID register this cycle.
REQ-013 SHALL have port bubble_count, output, CNT_W: count of load-use bubbles inserted.

Function
REQ-014 SHALL compute stall = id_valid & ex_valid & ex_control[3] & ~ex_control[1] & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Qualifies a load-use hazard.
- The ~branch term excludes jal, jalr and auipc, which the decoder drives with memread=1.
REQ-015 SHALL, on each clock edge when flush=1, load ex_valid=0 and ex_control=0 and hold all data fields, regardless of stall.
REQ-016 SHALL, on each clock edge when flush=0 and stall=1, insert a bubble.
- ex_valid=0 and ex_control=0.
- All data fields hold.
- bubble_count increments by 1.
REQ-017 SHALL, on each clock edge when flush=0 and stall=0, load every ex_* data field from its id_* input and set ex_valid=id_valid.
REQ-018 SHALL, in the REQ-017 case, load ex_control[9:1] = id_control[9:1] if id_valid=1, else 0.
REQ-019 SHALL, in the REQ-017 case, load ex_control[0] = id_valid & id_control[0] & id_control[3] & ~id_control[1].
- Only loads carry memtoreg=1.
- An undriven or X memtoreg from non-load opcodes never propagates.
REQ-020 SHALL deassert stall on the cycle after a bubble, because ex_valid=0; each load-use hazard therefore costs exactly one bubble.
REQ-021 SHALL saturate bubble_count at 2^CNT_W-1 and never wrap.
REQ-022 SHALL NOT increment bubble_count on flush, including when flush and stall are both asserted.
REQ-023 SHALL hold every stage register constant across cycles for unchanged inputs with stall=0 and flush=0 (plain pipeline register, latency 1 cycle).

Reset
REQ-024 SHALL, while reset=1, force every ex_* output and bubble_count to 0 immediately, independent of clk.
REQ-025 SHALL hold stall at 0 while reset=1, since ex_valid=0.
REQ-026 SHALL, on reset deassertion, resume normal loading on the next rising clk edge.

Verification
REQ-027 SHALL verify pass-through: id_valid=1, id_control=0x200 (ADD), id_rd=5, id_pc=0x40 -> next edge ex_control=0x200, ex_rd=5, ex_pc=0x40, ex_valid=1, stall=0.
REQ-028 SHALL verify load-use: EX holds ex_control=0x219 with ex_rd=3, and ID has id_rs1=3 -> stall=1 that cycle; next edge ex_valid=0, ex_control=0, bubble_count=1, stall=0.
REQ-029 SHALL verify x0 and jal exclusion.
- EX load with ex_rd=0 and id_rs2=0 -> stall=0.
- EX jal (memread=1, branch=1) with ex_rd=1 and id_rs1=1 -> stall=0.
- ID jal with id_control[0]=1 -> ex_control[0]=0 after load.
REQ-030 SHALL verify flush priority: flush=1 with a load-use hazard present -> next edge ex_valid=0, ex_control=0, bubble_count unchanged.
REQ-031 SHALL verify async reset mid-operation: reset pulsed between clk edges while ex_valid=1 and bubble_count=7 -> all outputs 0 before the next clk edge.
REQ-032 SHALL verify saturation: with CNT_W=2, four consecutive load-use hazards -> bubble_count reaches 3 and stays 3.
